// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the fetch stage and its skid buffer.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    S_BOOT  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instruction, pc} store that catches a fetched word while decode is stalled.
module fetch_skid_buffer
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            drain,
  input  logic            flush,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  // flush beats load so a redirect never leaves a wrong-path word behind
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage with IF/ID register: owns the PC, drives a busywait instruction port,
// absorbs decode stalls in a skid buffer and squashes wrong-path fetches on redirect.
module instruction_fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic         CLK,
  input  logic         RESET,
  output logic         imem_read,
  output logic [31:0]  imem_addr,
  input  logic [31:0]  imem_readdata,
  input  logic         imem_busywait,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_target,
  output logic [31:0]  if_id_instruction,
  output logic [31:0]  if_id_pc,
  output logic [31:0]  if_id_pc_plus4,
  output logic         if_id_valid,
  output fetch_state_e fetch_state
);

  // Memory handshake: a request is imem_read=1 with imem_addr stable; it completes at the
  // first rising edge where imem_busywait=0, and imem_readdata is valid in that cycle.
  // A request, once raised, is never withdrawn or re-addressed before it completes.

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q;
  logic [31:0]  kill_addr_q;
  logic         kill_q;

  logic         buf_valid;
  logic [31:0]  buf_instr;
  logic [31:0]  buf_pc;

  logic         accept;
  logic         outstanding;
  logic         fresh;
  logic         buf_load;
  logic         buf_drain;

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_BOOT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    imem_read = 1'b0;
    case (state_q)
      S_BOOT:  state_d   = S_FETCH;
      S_FETCH: imem_read = ~buf_valid;
      default: state_d   = S_BOOT;
    endcase
  end

  assign fetch_state = state_q;
  assign imem_addr   = kill_q ? kill_addr_q : pc_q;
  assign accept      = imem_read & ~imem_busywait;
  assign outstanding = imem_read & imem_busywait;
  // a completed access carries a usable word only if it is neither killed nor redirected away
  assign fresh       = accept & ~kill_q & ~redirect;
  assign buf_load    = fresh & stall;
  assign buf_drain   = ~redirect & ~stall & buf_valid;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      kill_addr_q <= RESET_PC;
    end else begin
      if (redirect)             pc_q <= word_align(redirect_target);
      else if (accept & ~kill_q) pc_q <= pc_q + 32'd4;

      if (kill_q) begin
        if (accept) kill_q <= 1'b0;
      end else if (redirect & outstanding) begin
        kill_q      <= 1'b1;
        kill_addr_q <= pc_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      if_id_instruction <= NOP_INSTR;
      if_id_pc          <= 32'd0;
      if_id_pc_plus4    <= 32'd4;
      if_id_valid       <= 1'b0;
    end else if (redirect) begin
      if_id_instruction <= NOP_INSTR;
      if_id_valid       <= 1'b0;
    end else if (~stall) begin
      if (buf_valid) begin
        if_id_instruction <= buf_instr;
        if_id_pc          <= buf_pc;
        if_id_pc_plus4    <= buf_pc + 32'd4;
        if_id_valid       <= 1'b1;
      end else if (fresh) begin
        if_id_instruction <= imem_readdata;
        if_id_pc          <= pc_q;
        if_id_pc_plus4    <= pc_q + 32'd4;
        if_id_valid       <= 1'b1;
      end else begin
        if_id_instruction <= NOP_INSTR;
        if_id_valid       <= 1'b0;
      end
    end
  end

  fetch_skid_buffer u_skid (
    .clk        (CLK),
    .reset      (RESET),
    .load       (buf_load),
    .drain      (buf_drain),
    .flush      (redirect),
    .load_instr (imem_readdata),
    .load_pc    (pc_q),
    .valid      (buf_valid),
    .instr      (buf_instr),
    .pc         (buf_pc)
  );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed pipeline scenarios plus a randomized stream
// checked against an in-order program-counter reference.
module tb_instruction_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         imem_read;
  logic [31:0]  imem_addr;
  logic [31:0]  imem_readdata;
  logic         imem_busywait;
  logic         stall;
  logic         redirect;
  logic [31:0]  redirect_target;
  logic [31:0]  if_id_instruction;
  logic [31:0]  if_id_pc;
  logic [31:0]  if_id_pc_plus4;
  logic         if_id_valid;
  fetch_state_e fetch_state;

  int checks = 0;
  int passed = 0;
  logic [31:0] exp_q[$];

  instruction_fetch_stage dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .imem_read         (imem_read),
    .imem_addr         (imem_addr),
    .imem_readdata     (imem_readdata),
    .imem_busywait     (imem_busywait),
    .stall             (stall),
    .redirect          (redirect),
    .redirect_target   (redirect_target),
    .if_id_instruction (if_id_instruction),
    .if_id_pc          (if_id_pc),
    .if_id_pc_plus4    (if_id_pc_plus4),
    .if_id_valid       (if_id_valid),
    .fetch_state       (fetch_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_readdata = mem_word(imem_addr);

  // driver tasks
  task automatic cycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic drive_idle();
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'd0;
    imem_busywait   = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    drive_idle();
    cycle();
    cycle();
    RESET = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    checks++; if (if_id_instruction !== NOP) $display("FAIL reset_instr got %h want %h", if_id_instruction, NOP); else passed++;
    checks++; if (if_id_pc !== 32'd0) $display("FAIL reset_pc got %h want 0", if_id_pc); else passed++;
    checks++; if (if_id_pc_plus4 !== 32'd4) $display("FAIL reset_pc4 got %h want 4", if_id_pc_plus4); else passed++;
    checks++; if (if_id_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", if_id_valid); else passed++;
    checks++; if (imem_read !== 1'b0) $display("FAIL reset_read got %b want 0", imem_read); else passed++;
    checks++; if (imem_addr !== 32'd0) $display("FAIL reset_addr got %h want 0", imem_addr); else passed++;
    checks++; if (fetch_state !== S_BOOT) $display("FAIL reset_state got %0d want BOOT", fetch_state); else passed++;
    cycle();
    checks++; if (fetch_state !== S_FETCH) $display("FAIL boot_state got %0d want FETCH", fetch_state); else passed++;
    checks++; if (imem_read !== 1'b1 || imem_addr !== 32'd0) $display("FAIL first_req got %b/%h want 1/0", imem_read, imem_addr); else passed++;
  endtask

  task automatic test_streaming();
    do_reset();
    cycle();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      cycle();
      e = 32'(4 * i);
      checks++;
      if (if_id_pc !== e || if_id_valid !== 1'b1 || if_id_instruction !== mem_word(e) || if_id_pc_plus4 !== e + 32'd4)
        $display("FAIL stream_%0d got pc %h v %b ins %h want pc %h v 1 ins %h", i, if_id_pc, if_id_valid, if_id_instruction, e, mem_word(e));
      else passed++;
    end
  endtask

  task automatic test_busywait();
    do_reset();
    run(3);
    checks++; if (imem_addr !== 32'h8) $display("FAIL bw_addr_pre got %h want 8", imem_addr); else passed++;
    imem_busywait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (imem_addr !== 32'h8 || imem_read !== 1'b1 || if_id_valid !== 1'b0 || if_id_instruction !== NOP)
        $display("FAIL bw_bubble_%0d got addr %h rd %b v %b ins %h want 8 1 0 %h", i, imem_addr, imem_read, if_id_valid, if_id_instruction, NOP);
      else passed++;
    end
    imem_busywait = 1'b0;
    cycle();
    checks++;
    if (if_id_pc !== 32'h8 || if_id_valid !== 1'b1 || if_id_instruction !== mem_word(32'h8))
      $display("FAIL bw_deliver got pc %h v %b want 8 1", if_id_pc, if_id_valid);
    else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    run(5);
    checks++; if (if_id_pc !== 32'hC || imem_addr !== 32'h10) $display("FAIL st_pre got pc %h addr %h want c 10", if_id_pc, imem_addr); else passed++;
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (if_id_pc !== 32'hC || if_id_valid !== 1'b1 || imem_read !== 1'b0)
        $display("FAIL st_hold_%0d got pc %h v %b rd %b want c 1 0", i, if_id_pc, if_id_valid, imem_read);
      else passed++;
    end
    stall = 1'b0;
    cycle();
    checks++;
    if (if_id_pc !== 32'h10 || if_id_valid !== 1'b1 || if_id_instruction !== mem_word(32'h10) || imem_read !== 1'b1 || imem_addr !== 32'h14)
      $display("FAIL st_drain got pc %h v %b rd %b addr %h want 10 1 1 14", if_id_pc, if_id_valid, imem_read, imem_addr);
    else passed++;
    cycle();
    checks++; if (if_id_pc !== 32'h14 || if_id_valid !== 1'b1) $display("FAIL st_resume got pc %h v %b want 14 1", if_id_pc, if_id_valid); else passed++;
  endtask

  task automatic test_redirect_kill();
    do_reset();
    run(9);
    checks++; if (imem_addr !== 32'h20) $display("FAIL rk_pre got %h want 20", imem_addr); else passed++;
    imem_busywait = 1'b1;
    cycle();
    redirect = 1'b1;
    redirect_target = 32'h0000_0103;
    cycle();
    redirect = 1'b0;
    checks++;
    if (imem_addr !== 32'h20 || imem_read !== 1'b1 || if_id_valid !== 1'b0 || if_id_instruction !== NOP)
      $display("FAIL rk_hold got addr %h rd %b v %b want 20 1 0", imem_addr, imem_read, if_id_valid);
    else passed++;
    cycle();
    checks++; if (imem_addr !== 32'h20) $display("FAIL rk_hold2 got %h want 20", imem_addr); else passed++;
    imem_busywait = 1'b0;
    cycle();
    checks++;
    if (if_id_valid !== 1'b0 || imem_addr !== 32'h100)
      $display("FAIL rk_discard got v %b addr %h want 0 100", if_id_valid, imem_addr);
    else passed++;
    cycle();
    checks++;
    if (if_id_pc !== 32'h100 || if_id_valid !== 1'b1 || if_id_instruction !== mem_word(32'h100))
      $display("FAIL rk_target got pc %h v %b want 100 1", if_id_pc, if_id_valid);
    else passed++;
  endtask

  task automatic test_redirect_stall();
    do_reset();
    run(5);
    stall = 1'b1;
    cycle();
    checks++; if (imem_read !== 1'b0) $display("FAIL rs_buf_full got rd %b want 0", imem_read); else passed++;
    redirect = 1'b1;
    redirect_target = 32'h100;
    cycle();
    redirect = 1'b0;
    stall = 1'b0;
    checks++;
    if (if_id_valid !== 1'b0 || if_id_instruction !== NOP || imem_read !== 1'b1 || imem_addr !== 32'h100)
      $display("FAIL rs_flush got v %b ins %h rd %b addr %h want 0 %h 1 100", if_id_valid, if_id_instruction, imem_read, imem_addr, NOP);
    else passed++;
    cycle();
    checks++; if (if_id_pc !== 32'h100 || if_id_valid !== 1'b1) $display("FAIL rs_target got pc %h v %b want 100 1", if_id_pc, if_id_valid); else passed++;
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    run(3);
    imem_busywait = 1'b1;
    cycle();
    RESET = 1'b1;
    cycle();
    checks++;
    if (if_id_instruction !== NOP || if_id_pc !== 32'd0 || if_id_pc_plus4 !== 32'd4 || if_id_valid !== 1'b0 ||
        imem_read !== 1'b0 || imem_addr !== 32'd0 || fetch_state !== S_BOOT)
      $display("FAIL rm_reset got ins %h pc %h v %b rd %b addr %h", if_id_instruction, if_id_pc, if_id_valid, imem_read, imem_addr);
    else passed++;
    RESET = 1'b0;
    imem_busywait = 1'b0;
    cycle();
    checks++; if (imem_read !== 1'b1 || imem_addr !== 32'd0) $display("FAIL rm_first got rd %b addr %h want 1 0", imem_read, imem_addr); else passed++;
    cycle();
    checks++; if (if_id_pc !== 32'd0 || if_id_valid !== 1'b1) $display("FAIL rm_deliver got pc %h v %b want 0 1", if_id_pc, if_id_valid); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    run(2);
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    cycle();
    redirect = 1'b0;
    cycle();
    checks++;
    if (if_id_pc !== 32'hFFFF_FFFC || if_id_pc_plus4 !== 32'd0 || if_id_valid !== 1'b1)
      $display("FAIL wrap_last got pc %h pc4 %h v %b want fffffffc 0 1", if_id_pc, if_id_pc_plus4, if_id_valid);
    else passed++;
    cycle();
    checks++; if (if_id_pc !== 32'd0 || if_id_valid !== 1'b1) $display("FAIL wrap_zero got pc %h v %b want 0 1", if_id_pc, if_id_valid); else passed++;
  endtask

  // scoreboard: decode must see consecutive PCs, restarting at each redirect target
  task automatic test_random();
    logic        p_stall, p_redir, p_read, p_busy;
    logic [31:0] p_addr, tgt, e;
    int          delivered;
    do_reset();
    exp_q.delete();
    exp_q.push_back(32'd0);
    p_stall = 1'b0; p_redir = 1'b0; p_read = 1'b0; p_busy = 1'b0; p_addr = 32'd0;
    delivered = 0;
    for (int c = 0; c < 400; c++) begin
      cycle();
      if (p_redir) begin
        checks++; if (if_id_valid !== 1'b0) $display("FAIL rnd_flush_%0d got v %b want 0", c, if_id_valid); else passed++;
      end else if (!p_stall && if_id_valid === 1'b1) begin
        e = exp_q.pop_front();
        exp_q.push_back(e + 32'd4);
        delivered++;
        checks++;
        if (if_id_pc !== e || if_id_instruction !== mem_word(e) || if_id_pc_plus4 !== e + 32'd4)
          $display("FAIL rnd_stream_%0d got pc %h ins %h want pc %h ins %h", c, if_id_pc, if_id_instruction, e, mem_word(e));
        else passed++;
      end
      if (p_read && p_busy) begin
        checks++;
        if (imem_read !== 1'b1 || imem_addr !== p_addr)
          $display("FAIL rnd_addr_stable_%0d got rd %b addr %h want 1 %h", c, imem_read, imem_addr, p_addr);
        else passed++;
      end
      stall         = ($urandom_range(0, 3) == 0);
      imem_busywait = ($urandom_range(0, 2) == 0);
      redirect      = ($urandom_range(0, 19) == 0);
      tgt = $urandom();
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | {28'd0, tgt[3:0]};
      else                           tgt = tgt & 32'h0000_0FFF;
      redirect_target = tgt;
      if (redirect) begin
        exp_q.delete();
        exp_q.push_back({tgt[31:2], 2'b00});
      end
      p_stall = stall; p_redir = redirect; p_busy = imem_busywait;
      p_read  = imem_read; p_addr = imem_addr;
    end
    drive_idle();
    checks++; if (delivered < 80) $display("FAIL rnd_throughput got %0d want >= 80", delivered); else passed++;
  endtask

  initial begin
    RESET = 1'b1;
    drive_idle();
    test_reset();
    test_streaming();
    test_busywait();
    test_stall();
    test_redirect_kill();
    test_redirect_stall();
    test_reset_mid_access();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
